// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its surroundings:
// lock/restart requests in, PLL reset, readiness and status out.
interface pll_lock_supervisor_if;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] lol_count;
  logic [2:0] state;

  modport master (
    output pll_locked, restart,
    input  pll_rst, ready, fault, retry_count, lol_count, state
  );

  modport slave (
    input  pll_locked, restart,
    output pll_rst, ready, fault, retry_count, lol_count, state
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses pll_rst, waits for a stable synchronized lock,
// releases ready, retries on timeout and re-runs the sequence on loss of lock.
module pll_lock_supervisor #(
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT    = 50000,
  parameter int unsigned LOCK_STABLE     = 256,
  parameter int unsigned MAX_RETRIES     = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pll_lock_supervisor_if.slave bus
);

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT);
  localparam int STB_W  = $clog2(LOCK_STABLE);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(LOCK_STABLE - 1);
  localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [STB_W-1:0]    stb_cnt_q, stb_cnt_d;
  logic [3:0]          retry_q, retry_d;
  logic [7:0]          lol_q, lol_d;
  logic                pll_rst_q, pll_rst_d;
  logic                ready_q, ready_d;
  logic                fault_q, fault_d;
  logic                lock_s;
  logic                timeout;
  logic                win_q, win_d;

  assign lock_s  = sync2_q;
  assign timeout = (to_cnt_q == TO_LAST);
  assign win_q   = (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE);
  assign win_d   = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lol_d   = lol_q;
    sync1_d = bus.pll_locked;
    sync2_d = sync1_q;

    if (bus.restart) begin
      state_d = ST_HOLD;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK, ST_STABLE: begin
          // The lock window timeout outranks any lock activity in the same cycle.
          if (timeout) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 4'd1;
              state_d = ST_HOLD;
            end else begin
              state_d = ST_FAULT;
            end
          end else if (state_q == ST_WAIT_LOCK) begin
            if (lock_s) state_d = ST_STABLE;
          end else if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (stb_cnt_q == STB_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_HOLD;
            if (lol_q != 8'hFF) lol_d = lol_q + 8'd1;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_HOLD;
      endcase
    end

    // Counters restart from zero on every entry into the phase they time.
    hold_cnt_d = (!bus.restart && state_q == ST_HOLD && state_d == ST_HOLD)
                 ? hold_cnt_q + HOLD_W'(1) : '0;
    to_cnt_d   = (win_q && win_d) ? to_cnt_q + TO_W'(1) : '0;
    stb_cnt_d  = (state_q == ST_STABLE && state_d == ST_STABLE)
                 ? stb_cnt_q + STB_W'(1) : '0;

    pll_rst_d = (state_d == ST_HOLD) || (state_d == ST_FAULT);
    ready_d   = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_HOLD;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      hold_cnt_q <= '0;
      to_cnt_q   <= '0;
      stb_cnt_q  <= '0;
      retry_q    <= '0;
      lol_q      <= '0;
      pll_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      hold_cnt_q <= hold_cnt_d;
      to_cnt_q   <= to_cnt_d;
      stb_cnt_q  <= stb_cnt_d;
      retry_q    <= retry_d;
      lol_q      <= lol_d;
      pll_rst_q  <= pll_rst_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.ready       = ready_q;
  assign bus.fault       = fault_q;
  assign bus.retry_count = retry_q;
  assign bus.lol_count   = lol_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock/restart/reset
// traffic, compared cycle by cycle against a behavioural model of the supervisor.
module tb_pll_lock_supervisor;
  localparam int T_HOLD = 4, T_TO = 20, T_STB = 8, N_RETRY = 2;
  localparam int S_HOLD = 0, S_WAIT = 1, S_STABLE = 2, S_RUN = 3, S_FAULT = 4;
  localparam logic [17:0] RST_V = {3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  pll_lock_supervisor_if bus();

  pll_lock_supervisor #(
    .RST_HOLD_CYCLES(T_HOLD),
    .LOCK_TIMEOUT(T_TO),
    .LOCK_STABLE(T_STB),
    .MAX_RETRIES(N_RETRY)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase, elapsed cycles since pll_rst release, good-lock run length.
  int m_st = 0, m_hold = 0, m_elapsed = 0, m_good = 0, m_retry = 0, m_lol = 0;
  bit m_s1 = 0, m_s2 = 0, m_lk = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_st = S_HOLD; m_hold = 0; m_elapsed = 0; m_good = 0;
      m_retry = 0; m_lol = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      m_lk = m_s2;
      m_s2 = m_s1;
      m_s1 = bus.pll_locked;
      if (bus.restart) begin
        m_st = S_HOLD; m_hold = 0; m_retry = 0;
      end else if (m_st == S_HOLD) begin
        if (m_hold == T_HOLD - 1) begin m_st = S_WAIT; m_elapsed = 0; end
        else m_hold++;
      end else if (m_st == S_WAIT || m_st == S_STABLE) begin
        if (m_elapsed == T_TO - 1) begin
          if (m_retry < N_RETRY) begin m_retry++; m_st = S_HOLD; m_hold = 0; end
          else m_st = S_FAULT;
        end else begin
          m_elapsed++;
          if (m_st == S_WAIT) begin
            if (m_lk) begin m_st = S_STABLE; m_good = 0; end
          end else if (!m_lk) m_st = S_WAIT;
          else if (m_good == T_STB - 1) begin m_st = S_RUN; m_retry = 0; end
          else m_good++;
        end
      end else if (m_st == S_RUN && !m_lk) begin
        m_lol = (m_lol < 255) ? m_lol + 1 : 255;
        m_st  = S_HOLD; m_hold = 0;
      end
    end
  end

  wire [17:0] exp_v = {m_st[2:0], (m_st == S_HOLD) || (m_st == S_FAULT), m_st == S_RUN,
                       m_st == S_FAULT, m_retry[3:0], m_lol[7:0]};
  wire [17:0] dut_v = {bus.state, bus.pll_rst, bus.ready, bus.fault,
                       bus.retry_count, bus.lol_count};

  // Any cycle following a reset edge must show ready low and pll_rst high.
  bit rst_seen = 1'b0;
  always @(posedge clk) rst_seen <= !reset_n;
  always @(negedge clk) begin
    if (rst_seen) begin
      checks++;
      assert (bus.ready === 1'b0 && bus.pll_rst === 1'b1)
      else begin
        errors++;
        $display("FAIL reset_assert ready=%b pll_rst=%b required ready=0 pll_rst=1",
                 bus.ready, bus.pll_rst);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input bit lk, input bit rs, input bit rn);
    bus.pll_locked = lk;
    bus.restart    = rs;
    reset_n        = rn;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_v !== RST_V) begin
        errors++;
        $display("FAIL reset_values dut=%h required=%h", dut_v, RST_V);
      end
    end
  endtask

  task automatic test_lock_const();
    int rst_cycles = 0;
    int ready_at = -1;
    cyc(1'b1, 1'b0, 1'b0);
    if (bus.pll_rst) rst_cycles++;
    for (int n = 1; n <= 30; n++) begin
      cyc(1'b1, 1'b0, 1'b1);
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL lock_const_step n=%0d dut=%h model=%h", n, dut_v, exp_v);
      end
      if (bus.pll_rst) rst_cycles++;
      if (bus.ready && ready_at < 0) ready_at = n;
    end
    checks++;
    if (rst_cycles != T_HOLD) begin
      errors++; $display("FAIL lock_const_rst_len got=%0d required=%0d", rst_cycles, T_HOLD);
    end
    checks++;
    if (ready_at != T_HOLD + 1 + T_STB) begin
      errors++; $display("FAIL lock_const_ready_cycle got=%0d required=%0d", ready_at, T_HOLD + 1 + T_STB);
    end
    checks++;
    if (bus.retry_count !== 4'd0 || bus.state !== 3'd3) begin
      errors++; $display("FAIL lock_const_final retry=%0d state=%0d required 0/3", bus.retry_count, bus.state);
    end
  endtask

  task automatic test_no_lock();
    int rises[$];
    int rise_retry[$];
    int fault_at = -1;
    bit prev;
    cyc(1'b0, 1'b0, 1'b0);
    prev = bus.pll_rst;
    for (int n = 1; n <= 90; n++) begin
      cyc(1'b0, 1'b0, 1'b1);
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL no_lock_step n=%0d dut=%h model=%h", n, dut_v, exp_v);
      end
      if (bus.pll_rst && !prev) begin rises.push_back(n); rise_retry.push_back(int'(bus.retry_count)); end
      prev = bus.pll_rst;
      if (bus.fault && fault_at < 0) fault_at = n;
    end
    checks++;
    if (rises.size() != 3) begin
      errors++; $display("FAIL no_lock_pulses got=%0d required=3", rises.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rises[i] != (i + 1) * (T_HOLD + T_TO) || rise_retry[i] != ((i + 1 < N_RETRY) ? i + 1 : N_RETRY)) begin
          errors++;
          $display("FAIL no_lock_attempt%0d at=%0d retry=%0d required at=%0d retry=%0d", i, rises[i],
                   rise_retry[i], (i + 1) * (T_HOLD + T_TO), (i + 1 < N_RETRY) ? i + 1 : N_RETRY);
        end
      end
    end
    checks++;
    if (fault_at != 3 * (T_HOLD + T_TO) || bus.state !== 3'd4 || bus.pll_rst !== 1'b1 || bus.fault !== 1'b1) begin
      errors++;
      $display("FAIL no_lock_fault at=%0d state=%0d pll_rst=%b fault=%b required at=%0d state=4 1 1",
               fault_at, bus.state, bus.pll_rst, bus.fault, 3 * (T_HOLD + T_TO));
    end
  endtask

  task automatic test_glitch();
    for (int it = 0; it < 4; it++) begin
      int g = $urandom_range(5, 10);
      bit seen_back = 0;
      int ready_at = -1;
      int max_retry = 0;
      logic [2:0] prev_st;
      cyc(1'b1, 1'b0, 1'b0);
      prev_st = bus.state;
      for (int n = 1; n <= 45; n++) begin
        bit lk = !(n == g || (it >= 2 && (n == g + 6 || n == g + 12)));
        cyc(lk, 1'b0, 1'b1);
        checks++;
        if (dut_v !== exp_v) begin
          errors++; $display("FAIL glitch_step it=%0d n=%0d dut=%h model=%h", it, n, dut_v, exp_v);
        end
        if (prev_st == 3'd2 && bus.state == 3'd1) seen_back = 1;
        prev_st = bus.state;
        if (bus.ready && ready_at < 0) ready_at = n;
        if (int'(bus.retry_count) > max_retry) max_retry = int'(bus.retry_count);
      end
      checks++;
      if (!seen_back) begin
        errors++; $display("FAIL glitch_back_to_wait it=%0d got=0 required=1", it);
      end
      checks++;
      if (it < 2 && (ready_at != g + 3 + T_STB || max_retry != 0)) begin
        errors++; $display("FAIL glitch_single it=%0d ready_at=%0d retry=%0d required %0d/0", it, ready_at, max_retry, g + 3 + T_STB);
      end else if (it >= 2 && (max_retry != 1 || ready_at <= T_HOLD + T_TO)) begin
        errors++; $display("FAIL glitch_timeout it=%0d ready_at=%0d retry=%0d required retry=1", it, ready_at, max_retry);
      end
    end
  endtask

  task automatic test_lol();
    bit up = 0;
    cyc(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 40 && !up; n++) begin
      cyc(1'b1, 1'b0, 1'b1);
      up = bus.ready;
    end
    checks++;
    if (!up) begin
      errors++; $display("FAIL lol_initial_run ready=0 required=1");
      return;
    end
    for (int i = 1; i <= 300; i++) begin
      int rst_cnt = 0;
      up = 0;
      for (int j = 0; j < 3; j++) begin
        cyc(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.ready !== (j < 2) || dut_v !== exp_v) begin
          errors++; $display("FAIL lol_drop i=%0d j=%0d ready=%b required=%b dut=%h model=%h",
                             i, j, bus.ready, j < 2, dut_v, exp_v);
        end
        if (bus.pll_rst) rst_cnt++;
      end
      for (int n = 0; n < 60 && !up; n++) begin
        cyc(1'b1, 1'b0, 1'b1);
        checks++;
        if (dut_v !== exp_v) begin
          errors++; $display("FAIL lol_regain i=%0d dut=%h model=%h", i, dut_v, exp_v);
        end
        if (bus.pll_rst) rst_cnt++;
        up = bus.ready;
      end
      checks++;
      if (!up) begin
        errors++; $display("FAIL lol_regain_timeout i=%0d ready=0 required=1", i);
        return;
      end
      checks++;
      if (int'(bus.lol_count) != ((i > 255) ? 255 : i) || rst_cnt != T_HOLD) begin
        errors++; $display("FAIL lol_count i=%0d lol=%0d rst_len=%0d required %0d/%0d",
                           i, bus.lol_count, rst_cnt, (i > 255) ? 255 : i, T_HOLD);
      end
    end
  endtask

  task automatic test_restart();
    int rst_cnt = 0;
    cyc(1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 80; n++) begin
      cyc(1'b0, 1'b0, 1'b1);
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL restart_pre n=%0d dut=%h model=%h", n, dut_v, exp_v);
      end
    end
    cyc(1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.state !== 3'd0 || bus.fault !== 1'b0 || bus.retry_count !== 4'd0 || bus.pll_rst !== 1'b1) begin
      errors++; $display("FAIL restart_from_fault state=%0d fault=%b retry=%0d required 0/0/0",
                         bus.state, bus.fault, bus.retry_count);
    end
    // Second attempt times out on the edge after observation 2*(hold+timeout)-1.
    cyc(1'b0, 1'b0, 1'b0);
    for (int n = 1; n < 2 * (T_HOLD + T_TO); n++) cyc(1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.state !== 3'd1 || bus.retry_count !== 4'd1) begin
      errors++; $display("FAIL restart_timeout_pre state=%0d retry=%0d required 1/1", bus.state, bus.retry_count);
    end
    cyc(1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.state !== 3'd0 || bus.retry_count !== 4'd0 || bus.fault !== 1'b0) begin
      errors++; $display("FAIL restart_with_timeout state=%0d retry=%0d required 0/0", bus.state, bus.retry_count);
    end
    if (bus.pll_rst) rst_cnt++;
    for (int n = 0; n < 6; n++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (bus.pll_rst) rst_cnt++;
    end
    checks++;
    if (rst_cnt != T_HOLD) begin
      errors++; $display("FAIL restart_hold_len got=%0d required=%0d", rst_cnt, T_HOLD);
    end
  endtask

  task automatic test_reset_mid();
    int rst_cnt = 0;
    cyc(1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 10; n++) cyc(1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.state !== 3'd1) begin
      errors++; $display("FAIL reset_mid_wait_pre state=%0d required=1", bus.state);
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_v !== RST_V) begin
      errors++; $display("FAIL reset_mid_wait dut=%h required=%h", dut_v, RST_V);
    end
    for (int n = 1; n <= 20; n++) cyc(1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) cyc(1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 30 && !bus.ready; n++) cyc(1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.state !== 3'd3 || bus.lol_count !== 8'd1) begin
      errors++; $display("FAIL reset_mid_run_pre state=%0d lol=%0d required 3/1", bus.state, bus.lol_count);
    end
    cyc(1'b1, 1'b0, 1'b0);
    checks++;
    if (dut_v !== RST_V) begin
      errors++; $display("FAIL reset_mid_run dut=%h required=%h", dut_v, RST_V);
    end
    if (bus.pll_rst) rst_cnt++;
    for (int n = 1; n <= 6; n++) begin
      cyc(1'b1, 1'b0, 1'b1);
      if (bus.pll_rst) rst_cnt++;
    end
    checks++;
    if (rst_cnt != T_HOLD) begin
      errors++; $display("FAIL reset_mid_hold_len got=%0d required=%0d", rst_cnt, T_HOLD);
    end
  endtask

  task automatic test_random();
    int run_left = 0;
    bit lk = 0;
    cyc(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      bit rs, rn;
      if (run_left == 0) begin
        lk = !lk;
        run_left = lk ? $urandom_range(1, 60) : $urandom_range(1, 8);
      end
      run_left--;
      rs = ($urandom_range(0, 199) == 0);
      rn = ($urandom_range(0, 399) != 0);
      cyc(lk, rs, rn);
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL random_step n=%0d dut=%h model=%h", n, dut_v, exp_v);
      end
    end
  endtask

  initial begin
    bus.pll_locked = 1'b0;
    bus.restart    = 1'b0;
    reset_n        = 1'b0;
    test_reset();
    test_lock_const();
    test_no_lock();
    test_glitch();
    test_lol();
    test_restart();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter RST_HOLD_CYCLES, default 16, SHALL set the number of cycles pll_rst is held per attempt (range 2..65535).
REQ-002 Parameter LOCK_TIMEOUT, default 50000, SHALL set the maximum cycles allowed from pll_rst release to stable lock (range 4..2^20-1).
REQ-003 Parameter LOCK_STABLE, default 256, SHALL set the number of consecutive synchronized-lock-high cycles required before ready (range 2..65535).
REQ-004 Parameter MAX_RETRIES, default 3, SHALL set the number of re-attempts after the first failed attempt (range 0..15).
REQ-005 clk  in  1  single clock, free-running reference domain; all logic is on its rising edge.
REQ-006 reset_n  in  1  reset, synchronous, active-low.
REQ-007 pll_locked  in  1  PLL lock indicator, asynchronous to clk.
REQ-008 restart  in  1  single-cycle request to restart the sequence.
REQ-009 pll_rst  out  1  active-high reset to the PLL.
REQ-010 ready  out  1  high only while the PLL output clocks are usable; used as downstream reset release.
REQ-011 fault  out  1  retries exhausted.
REQ-012 retry_count  out  4  failed attempts in the current sequence.
REQ-013 lol_count  out  8  loss-of-lock events seen in RUN, saturating.
REQ-014 state  out  3  encoding: HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; lock_s (2nd flop) SHALL be the only lock signal used; both flops SHALL clear on reset.
REQ-016 HOLD: pll_rst=1; hold counter SHALL count from 0; at count RST_HOLD_CYCLES-1 the FSM SHALL go to WAIT_LOCK, clear the timeout counter, and pll_rst SHALL be 0 from the next cycle.
REQ-017 The timeout counter SHALL increment every cycle in WAIT_LOCK and STABLE and SHALL NOT clear on a WAIT_LOCK/STABLE transition.
REQ-018 WAIT_LOCK: lock_s=1 -> STABLE with stable counter cleared.
REQ-019 STABLE: lock_s=0 -> WAIT_LOCK; stable counter reaching LOCK_STABLE-1 with lock_s=1 -> RUN.
REQ-020 In WAIT_LOCK or STABLE, timeout counter reaching LOCK_TIMEOUT-1 SHALL take priority over lock events: if retry_count<MAX_RETRIES then retry_count+1 and go to HOLD, else go to FAULT.
REQ-021 RUN: ready=1, pll_rst=0, retry_count cleared on entry.
REQ-022 RUN with lock_s=0: lol_count+1 (saturate at 255), ready=0 in the same cycle as the state change (registered, one cycle after lock_s falls), go to HOLD.
REQ-023 FAULT: pll_rst=1, fault=1, ready=0; exit only via restart or reset.
REQ-024 restart=1 in any state SHALL go to HOLD next cycle, clear the hold counter, retry_count and fault; lol_count SHALL be kept. restart SHALL take priority over every other transition.
REQ-025 ready SHALL be a registered output equal to (state==RUN); ready SHALL never be 1 while pll_rst=1.
REQ-026 Counters SHALL be sized to their parameters; no counter SHALL wrap.

Reset
REQ-027 With reset_n=0 at a clock edge, the next values SHALL be: state=HOLD, pll_rst=1, ready=0, fault=0, retry_count=0, lol_count=0, all internal counters and synchronizer flops 0.
REQ-028 Reset asserted in any state, mid-count, SHALL behave the same as power-up reset; the first HOLD SHALL last a full RST_HOLD_CYCLES after reset_n rises.

Verification (RST_HOLD_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2)
REQ-029 Release reset, pll_locked=1 constant -> pll_rst=1 for 4 cycles; ready rises at a deterministic cycle (4 hold + 2 sync + 8 stable, ±1 registered); retry_count=0.
REQ-030 pll_locked=0 constant -> three attempts of 4-cycle pll_rst pulses, 20 cycles apart; retry_count goes 1, 2; then state=4, fault=1, pll_rst=1 held.
REQ-031 Lock glitches low for 1 cycle during STABLE, then stays high -> FSM returns to WAIT_LOCK, re-enters STABLE, reaches RUN only if all within 20 cycles of pll_rst release, otherwise retry_count=1.
REQ-032 In RUN, drop pll_locked for 3 cycles -> ready falls one cycle after lock_s falls, lol_count=1, new 4-cycle pll_rst pulse, RUN regained; repeat 300 times -> lol_count=255.
REQ-033 From FAULT, pulse restart -> fault=0, retry_count=0, HOLD; also restart in the same cycle as a timeout -> HOLD, with retry_count=0.
REQ-034 Assert reset_n=0 mid-WAIT_LOCK and mid-RUN -> all outputs match REQ-027 on the next cycle; ready=0 and pll_rst=1 checked at every cycle by assertion.
